// File: rtl/rvz_hazard_ctrl.sv
// Scoreboard issue controller for riscv_zero: RAW/WAW/fence stalls and
// redirect flush windows between decode and execute.
module rvz_hazard_ctrl #(
  parameter int NREG      = 32,
  parameter int CNT_W     = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_wb_en,
  input  logic        id_fence,
  input  logic        ex_redirect,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        issue,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_if,
  output logic        flush_id,
  output logic        sb_busy,
  output logic        sb_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  state_t           state;
  logic [3:0]       fcnt;
  logic [CNT_W-1:0] cnt   [NREG];
  logic [CNT_W-1:0] cnt_n [NREG];
  logic             busy_n;
  logic             uflow;
  logic             run;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             fen;
  logic             hazard;
  logic             inc;
  logic             dec;

  assign run    = (state == RUN);
  assign raw1   = id_rs1_used && id_rs1 != 5'd0 && cnt[id_rs1] != '0;
  assign raw2   = id_rs2_used && id_rs2 != 5'd0 && cnt[id_rs2] != '0;
  assign waw    = id_wb_en && id_rd != 5'd0 && cnt[id_rd] == CMAX;
  assign fen    = id_fence && sb_busy;
  assign hazard = run && id_valid && (raw1 || raw2 || waw || fen);

  // Outputs forced quiet while reset is held so the pipe sees no activity.
  assign stall_id = ~reset & hazard & ~ex_redirect;
  assign stall_if = stall_id;
  assign issue    = ~reset & id_valid & ~hazard & run & ~ex_redirect;
  assign flush_if = ~reset & (~run | ex_redirect);
  assign flush_id = flush_if;

  assign inc = issue && id_wb_en && id_rd != 5'd0;
  assign dec = wb_valid && wb_rd != 5'd0;

  always_comb begin
    cnt_n  = cnt;
    uflow  = 1'b0;
    busy_n = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (inc && id_rd == 5'(r) && !(dec && wb_rd == 5'(r))) begin
        cnt_n[r] = cnt[r] + 1'b1;
      end else if (dec && wb_rd == 5'(r) && !(inc && id_rd == 5'(r))) begin
        if (cnt[r] == '0) uflow = 1'b1;
        else cnt_n[r] = cnt[r] - 1'b1;
      end
    end
    cnt_n[0] = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_n = busy_n | (cnt_n[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= 4'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_redirect) begin
            state <= FLUSH;
            fcnt  <= 4'(FLUSH_CYC);
          end
        end
        FLUSH: begin
          if (ex_redirect) begin
            fcnt <= 4'(FLUSH_CYC);
          end else if (fcnt == 4'd1) begin
            state <= RUN;
            fcnt  <= 4'd0;
          end else begin
            fcnt <= fcnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_busy      <= 1'b0;
      sb_err       <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      cnt     <= cnt_n;
      sb_busy <= busy_n;
      if (uflow) sb_err <= 1'b1;
      if (stall_id && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_rvz_hazard_ctrl.sv
// Directed plus random bench for rvz_hazard_ctrl against a
// per-register outstanding-count reference model.
module tb_rvz_hazard_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_rs1_used, id_rs2_used, id_wb_en, id_fence;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        ex_redirect, wb_valid;
  logic        issue, stall_if, stall_id, flush_if, flush_id;
  logic        sb_busy, sb_err;
  logic [31:0] stall_cycles;

  rvz_hazard_ctrl #(.NREG(32), .CNT_W(2), .FLUSH_CYC(FC)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wb_en(id_wb_en), .id_fence(id_fence),
    .ex_redirect(ex_redirect), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue(issue), .stall_if(stall_if), .stall_id(stall_id),
    .flush_if(flush_if), .flush_id(flush_id),
    .sb_busy(sb_busy), .sb_err(sb_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     mcnt[32];
  int     mflush;
  bit     merr, mbusy;
  longint mstall;
  bit     e_issue, e_stall, e_flush;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mcnt[i]) mcnt[i] = 0;
    mflush = 0; merr = 0; mbusy = 0; mstall = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0;
    id_rs2_used = 0; id_rd = 0; id_wb_en = 0; id_fence = 0;
    ex_redirect = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic model_comb();
    bit haz;
    haz = 0;
    if (mflush == 0 && id_valid) begin
      if (id_rs1_used && id_rs1 != 0 && mcnt[id_rs1] > 0) haz = 1;
      if (id_rs2_used && id_rs2 != 0 && mcnt[id_rs2] > 0) haz = 1;
      if (id_wb_en && id_rd != 0 && mcnt[id_rd] == 3) haz = 1;
      if (id_fence && mbusy) haz = 1;
    end
    e_stall = haz && !ex_redirect;
    e_issue = id_valid && !haz && mflush == 0 && !ex_redirect;
    e_flush = mflush != 0 || ex_redirect;
  endtask

  task automatic model_update();
    bit inc, dec;
    inc = e_issue && id_wb_en && id_rd != 0;
    dec = wb_valid && wb_rd != 0;
    if (ex_redirect) mflush = FC;
    else if (mflush > 0) mflush--;
    if (inc && dec && id_rd == wb_rd) begin
    end else begin
      if (inc) mcnt[id_rd]++;
      if (dec) begin
        if (mcnt[wb_rd] > 0) mcnt[wb_rd]--;
        else merr = 1;
      end
    end
    mbusy = 0;
    foreach (mcnt[i]) if (mcnt[i] > 0) mbusy = 1;
    if (e_stall && mstall < 64'hFFFF_FFFF) mstall++;
  endtask

  // Inputs must already be applied; checks, clocks, and returns at negedge.
  task automatic step(input string tag);
    #1;
    model_comb();
    chk({tag, ".issue"}, 32'(issue), 32'(e_issue));
    chk({tag, ".stall_if"}, 32'(stall_if), 32'(e_stall));
    chk({tag, ".stall_id"}, 32'(stall_id), 32'(e_stall));
    chk({tag, ".flush_if"}, 32'(flush_if), 32'(e_flush));
    chk({tag, ".flush_id"}, 32'(flush_id), 32'(e_flush));
    chk({tag, ".sb_busy"}, 32'(sb_busy), 32'(mbusy));
    chk({tag, ".sb_err"}, 32'(sb_err), 32'(merr));
    chk({tag, ".stall_cycles"}, stall_cycles, mstall[31:0]);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    #1;
    chk({tag, ".rst_issue"}, 32'(issue), 32'd0);
    chk({tag, ".rst_stall"}, 32'(stall_id | stall_if), 32'd0);
    chk({tag, ".rst_flush"}, 32'(flush_if | flush_id), 32'd0);
    chk({tag, ".rst_busy"}, 32'(sb_busy), 32'd0);
    chk({tag, ".rst_err"}, 32'(sb_err), 32'd0);
    chk({tag, ".rst_stallcnt"}, stall_cycles, 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic wr(input logic [4:0] rd);
    idle(); id_valid = 1; id_rd = rd; id_wb_en = 1;
  endtask

  initial begin
    int r;
    idle();
    model_clear();
    @(negedge clk);
    do_reset("init");

    // RAW on x5, no write-through on the retire cycle
    wr(5); step("t1_add");
    idle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    step("t1_s0"); step("t1_s1"); step("t1_s2");
    wb_valid = 1; wb_rd = 5; step("t1_wb");
    wb_valid = 0; step("t1_iss");
    chk("t1_stall_len", stall_cycles, 32'd4);

    // WAW saturation on x7
    wr(7); step("t2_w1"); step("t2_w2"); step("t2_w3");
    step("t2_sat");
    wb_valid = 1; wb_rd = 7; step("t2_wb");
    wb_valid = 0; step("t2_iss");
    chk("t2_cnt7", 32'(mcnt[7]), 32'd3);
    idle(); wb_valid = 1; wb_rd = 7;
    step("t2_d0"); step("t2_d1"); step("t2_d2");

    // Simultaneous issue and retire of x9
    wr(9); step("t3_w");
    wb_valid = 1; wb_rd = 9; step("t3_same");
    idle(); step("t3_chk");
    wb_valid = 1; wb_rd = 9; step("t3_drain");

    // Redirect flush window
    idle(); id_valid = 1; ex_redirect = 1; step("t4_pulse");
    ex_redirect = 0; step("t4_f1"); step("t4_f2"); step("t4_run");

    // Fence drain plus x0 source
    wr(10); step("t5_w10");
    wr(11); step("t5_w11");
    idle(); id_valid = 1; id_fence = 1; step("t5_f0");
    wb_valid = 1; wb_rd = 10; step("t5_wb10");
    wb_rd = 11; step("t5_wb11");
    wb_valid = 0; step("t5_iss");
    idle(); id_valid = 1; id_rs1 = 0; id_rs1_used = 1; step("t5_x0");

    // Underflow then reset mid-flush
    idle(); wb_valid = 1; wb_rd = 4; step("t6_uf");
    wb_valid = 0; step("t6_sticky");
    id_valid = 1; ex_redirect = 1; step("t6_rd");
    ex_redirect = 0; step("t6_fl");
    wr(12); do_reset("t6");
    idle(); step("t6_post");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      id_valid    = ($urandom % 4) != 0;
      id_rs1      = 5'($urandom % 8);
      id_rs2      = 5'($urandom % 8);
      id_rs1_used = ($urandom % 3) != 0;
      id_rs2_used = ($urandom % 3) == 0;
      id_rd       = 5'($urandom % 8);
      id_wb_en    = ($urandom % 4) != 0;
      id_fence    = ($urandom % 12) == 0;
      ex_redirect = ($urandom % 20) == 0;
      r = $urandom % 8;
      wb_rd = 5'(r);
      wb_valid = (mcnt[r] > 0) ? (($urandom % 2) == 0)
                               : (($urandom % 40) == 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
